// File: rtl/vtm_tpg.sv
// Test-pattern generator behind the video timing generator: 2-cycle timing pipe,
// pattern data mux and sticky geometry checks. Optional cursor overlay: `TPG_CURSOR_EN.
module vtm_tpg #(
    parameter int DWID     = 10,
    parameter int HWIN     = 640,
    parameter int VWIN     = 480,
    parameter int NBAR     = 8,
    parameter int CHK_LOG2 = 4,
    localparam int CW      = $clog2((HWIN > VWIN) ? HWIN : VWIN) + 1
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            i_tpg_en,
    input  logic [2:0]      i_tpg_mode,
    input  logic [DWID-1:0] i_tpg_solid,
    input  logic            i_err_clr,
    input  logic            i_fstr,
    input  logic            i_fend,
    input  logic            i_vstr,
    input  logic            i_vend,
    input  logic            i_vref,
    input  logic            i_hstr,
    input  logic            i_hend,
    input  logic            i_href,
`ifdef TPG_CURSOR_EN
    input  logic [CW-1:0]   i_cur_x,
    input  logic [CW-1:0]   i_cur_y,
`endif
    output logic            o_fstr,
    output logic            o_fend,
    output logic            o_vstr,
    output logic            o_vend,
    output logic            o_vref,
    output logic            o_hstr,
    output logic            o_hend,
    output logic            o_href,
    output logic [DWID-1:0] o_data,
    output logic            o_lerr,
    output logic            o_ferr
);

    localparam int NBW = (NBAR > 1) ? $clog2(NBAR) : 1;
    localparam int BPX = HWIN / NBAR;
    localparam int BCW = (BPX > 1) ? $clog2(BPX) : 1;
    localparam int BSH = DWID - NBW;

    localparam logic [BCW-1:0] BAR_LAST = BCW'(BPX - 1);
    localparam logic [BCW-1:0] BAR_ONE  = BCW'(1'b1);
    localparam logic [NBW-1:0] IDX_ONE  = NBW'(1'b1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
    localparam logic [CW:0]    CHK_ONE  = (CW+1)'(1'b1);
    localparam logic [CW:0]    HWIN_X   = (CW+1)'(HWIN);
    localparam logic [CW:0]    VWIN_X   = (CW+1)'(VWIN);

    logic [7:0]      tim1_r;
    logic [7:0]      tim2_r;
    logic            en_r;
    logic [2:0]      mode_r;
    logic [DWID-1:0] solid_r;
    logic [CW-1:0]   x_cnt_r;
    logic [CW-1:0]   y_cnt_r;
    logic [BCW-1:0]  bar_cnt_r;
    logic [NBW-1:0]  bar_idx_r;
    logic [7:0]      fm_cnt_r;
    logic [CW-1:0]   x1_r;
    logic [CW-1:0]   y1_r;
    logic [NBW-1:0]  bar1_r;
    logic [7:0]      fm1_r;
    logic [DWID-1:0] pix_s;
    logic [DWID-1:0] data_s;
    logic            cur_hit_s;
    logic            line_bad_s;
    logic            frame_bad_s;

    assign {o_fstr, o_fend, o_vstr, o_vend, o_vref, o_hstr, o_hend, o_href} = tim2_r;

    // Two-flop timing pipe
    always_ff @(posedge pclk) begin
        if (prst) begin
            tim1_r <= 8'h00;
            tim2_r <= 8'h00;
        end else begin
            tim1_r <= {i_fstr, i_fend, i_vstr, i_vend, i_vref, i_hstr, i_hend, i_href};
            tim2_r <= tim1_r;
        end
    end

`ifdef TPG_CURSOR_EN
    logic [CW-1:0] cur_x_r;
    logic [CW-1:0] cur_y_r;

    // Cursor position shadows, frame-stable like the pattern settings
    always_ff @(posedge pclk) begin
        if (prst) begin
            cur_x_r <= {CW{1'b0}};
            cur_y_r <= {CW{1'b0}};
        end else if (i_fstr) begin
            cur_x_r <= i_cur_x;
            cur_y_r <= i_cur_y;
        end
    end

    assign cur_hit_s = (x1_r == cur_x_r) || (y1_r == cur_y_r);
`else
    assign cur_hit_s = 1'b0;
`endif

    // Pattern shadows loaded at frame start
    always_ff @(posedge pclk) begin
        if (prst) begin
            en_r    <= 1'b0;
            mode_r  <= 3'd0;
            solid_r <= {DWID{1'b0}};
        end else if (i_fstr) begin
            en_r    <= i_tpg_en;
            mode_r  <= i_tpg_mode;
            solid_r <= i_tpg_solid;
        end
    end

    // Stage 1: pixel/line/bar/frame counters and per-pixel coordinate capture
    always_ff @(posedge pclk) begin
        if (prst) begin
            x_cnt_r   <= {CW{1'b0}};
            y_cnt_r   <= {CW{1'b0}};
            bar_cnt_r <= {BCW{1'b0}};
            bar_idx_r <= {NBW{1'b0}};
            fm_cnt_r  <= 8'd0;
            x1_r      <= {CW{1'b0}};
            y1_r      <= {CW{1'b0}};
            bar1_r    <= {NBW{1'b0}};
            fm1_r     <= 8'd0;
        end else begin
            if (i_hend) begin
                x_cnt_r   <= {CW{1'b0}};
                bar_cnt_r <= {BCW{1'b0}};
                bar_idx_r <= {NBW{1'b0}};
            end else if (i_href) begin
                if (x_cnt_r != CNT_MAX) begin
                    x_cnt_r <= x_cnt_r + CNT_ONE;
                end
                // Bar index advances on an in-bar counter instead of dividing x
                if (bar_cnt_r == BAR_LAST) begin
                    bar_cnt_r <= {BCW{1'b0}};
                    bar_idx_r <= bar_idx_r + IDX_ONE;
                end else begin
                    bar_cnt_r <= bar_cnt_r + BAR_ONE;
                end
            end
            if (i_vstr) begin
                y_cnt_r <= {CW{1'b0}};
            end else if (i_hend && i_vref && (y_cnt_r != CNT_MAX)) begin
                y_cnt_r <= y_cnt_r + CNT_ONE;
            end
            if (i_fend) begin
                fm_cnt_r <= fm_cnt_r + 8'd1;
            end
            x1_r   <= x_cnt_r;
            y1_r   <= i_vstr ? {CW{1'b0}} : y_cnt_r;
            bar1_r <= bar_idx_r;
            fm1_r  <= fm_cnt_r;
        end
    end

    // Pattern select and blanking/enable gating
    always_comb begin
        pix_s = {DWID{1'b0}};
        case (mode_r)
            3'd0:    pix_s = solid_r;
            3'd1:    pix_s = DWID'(bar1_r) << BSH;
            3'd2:    pix_s = DWID'(x1_r);
            3'd3:    pix_s = DWID'(y1_r);
            3'd4:    pix_s = {DWID{x1_r[CHK_LOG2] ^ y1_r[CHK_LOG2]}};
            3'd5:    pix_s = DWID'(x1_r) + DWID'(y1_r) + DWID'(fm1_r);
            default: pix_s = {DWID{1'b0}};
        endcase
        if (!en_r || !tim1_r[0]) begin
            data_s = {DWID{1'b0}};
        end else if (cur_hit_s) begin
            data_s = {DWID{1'b1}};
        end else begin
            data_s = pix_s;
        end
    end

    // Stage 2: registered pixel
    always_ff @(posedge pclk) begin
        if (prst) begin
            o_data <= {DWID{1'b0}};
        end else begin
            o_data <= data_s;
        end
    end

    // Geometry checks; counts are extended by one bit so the +1 cannot wrap
    always_comb begin
        line_bad_s  = (({1'b0, x_cnt_r} + CHK_ONE) != HWIN_X);
        frame_bad_s = (({1'b0, y_cnt_r} + CHK_ONE) != VWIN_X);
    end

    // Sticky error flags; a new error takes priority over a clear
    always_ff @(posedge pclk) begin
        if (prst) begin
            o_lerr <= 1'b0;
            o_ferr <= 1'b0;
        end else begin
            if (i_hend && line_bad_s) begin
                o_lerr <= 1'b1;
            end else if (i_err_clr) begin
                o_lerr <= 1'b0;
            end
            if (i_vend && frame_bad_s) begin
                o_ferr <= 1'b1;
            end else if (i_err_clr) begin
                o_ferr <= 1'b0;
            end
        end
    end

endmodule
